ram_arb_2m: RTL
===============

Name: ram_arb_2m

Overview:
- Two-requester arbiter and sequencer for the on-chip 2048x32 single-port RAM (altsyncram, byte-enabled, clken-gated).
- Sits between two Avalon-MM style masters (m0, m1) and the RAM's single slave port.
- Grants one access per cycle using round-robin, with optional per-master lock for read-modify-write sequences.
- Returns read data with fixed one-cycle latency, tagged back to the issuing master.

Parameters:
- ADDR_W, 11, RAM word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_LOCK, 4, maximum consecutive cycles one master may hold a lock (range 1..15).

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- mN_address  in  ADDR_W  word address (N = 0, 1, same for all mN_ ports).
- mN_byteenable  in  DATA_W/8  byte lanes for writes.
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_writedata  in  DATA_W  write data.
- mN_lock  in  1  hold grant on following cycles.
- mN_waitrequest  out  1  request not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  mN_readdata valid this cycle.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_clken  out  1  to RAM clken.
- ram_readdata  in  DATA_W  RAM q (address registered inside RAM, output unregistered).

Behaviour:
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, treat as a write.
- Grant decision: combinational each cycle from the current state.
  - Access issues in the same cycle it is granted.
  - mN_waitrequest = reqN & ~grantN.
  - While reset is high: both waitrequests = 1; no grant.
- RAM drive:
  - Granted master's address, byteenable and writedata are muxed to the ram_ signals.
  - ram_chipselect = any grant.
  - ram_write = granted write.
  - With no grant: ram_address and ram_writedata hold their last value; ram_byteenable = 0.
- Clock enable: ram_clken = any grant OR rd_pend. This keeps q stable while idle.
- Read return:
  - Registered rd_pend and rd_owner capture each granted read.
  - On the next cycle: m<rd_owner>_readdatavalid = 1 and m<rd_owner>_readdata = ram_readdata.
  - The other master's readdatavalid = 0.
  - readdata is a direct mux of ram_readdata; it is don't-care when not valid.
  - Back-to-back reads give one valid per cycle.
- FSM states: ARB, OWN0, OWN1.
  - ARB: round-robin; priority goes to the master not granted most recently (pointer rr, reset 0 = m0 first).
    - Single requester: granted immediately.
    - On grant, rr flips to the other master.
    - If the granted master has lock = 1, go to OWNn and load lock_cnt = MAX_LOCK-1.
  - OWNn: only mN can be granted; the other master waits.
    - Each cycle mN issues with lock = 1: decrement lock_cnt.
    - Return to ARB when mN_lock drops, lock_cnt reaches 0, or mN has no request that cycle.
    - The exit cycle's access is still granted if requested.
    - In the exit cycle rr points at the other master.
    - Lock with MAX_LOCK = 1 behaves as no lock.
- Simultaneous events:
  - Lock exit and the other master's pending request in the same cycle: the other master wins the next cycle.
  - Same-address write then read: the read returns the new data, provided the RAM uses read-during-write old/new ordering by cycle. Guaranteed here because accesses are serialised one per cycle.
- Reset values: state = ARB, rr = 0, lock_cnt = 0, rd_pend = 0, rd_owner = 0, readdatavalid = 0.
  - Reset mid-read drops the pending valid.
  - Reset mid-lock returns to ARB.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined: adds output ports gnt_cnt0 and gnt_cnt1 (32-bit grant counters) and conflict_cnt (32-bit).
  - conflict_cnt increments on every cycle both masters request.
  - Counters wrap at 2^32 and clear on reset.
  - Adds input stats_clr, which synchronously zeroes all three counters; stats_clr has priority over increment in the same cycle.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum (ARB, OWN0, OWN1);
  - ADDR_W/DATA_W defaults;
  - master-index typedef;
  - lock counter width (4).
- One natural sub-module: ram_arb_rr, a 2-way round-robin picker with pointer and lock FSM, producing grant vector and owner.
- The top level contains the muxes, read-return pipeline and stats.

Test Plan:
- m0 writes 0xDEADBEEF to addr 5 with be = 4'hF; m0 reads addr 5 the next cycle → waitrequest 0 both cycles; m0_readdatavalid = 1 one cycle after the read with data 0xDEADBEEF.
- Both masters read continuously after reset → grants alternate m0, m1, m0, …; each readdatavalid is routed to the correct master with 1-cycle latency.
- m1 writes be = 4'b0010 data 0x0000AB00 to an addr holding 0x11223344, then reads → 0x1122AB44.
- m0 asserts lock with 6 consecutive reads while m1 requests, MAX_LOCK = 4 → m0 granted 4 cycles, then m1 granted; m1_waitrequest high during the first 4 cycles.
- Reset asserted mid-read (rd_pend = 1) → readdatavalid 0 next cycle; state ARB; m0 has first priority after release.
- With RAM_ARB_STATS_EN: 10 cycles of dual requests, then stats_clr pulse → conflict_cnt = 10, gnt_cnt0 = 5, gnt_cnt1 = 5, then all 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-master RAM arbiter.
// Pulled in by ram_arb_if, ram_arb_rr and ram_arb_2m.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int LOCK_W     = 4;

    typedef logic mst_t;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arb_if.sv
// Avalon-MM style master port bundle for the RAM arbiter.
// master drives requests; slave is the arbiter side.
interface ram_arb_if import ram_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                lock;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker with per-master lock window.
// Grant is combinational from the current state; pointer and lock count are registered.
module ram_arb_rr import ram_arb_pkg::*; #(
    parameter int MAX_LOCK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] grant,
    output mst_t       owner
);

    localparam logic [LOCK_W-1:0] CNT_INIT = LOCK_W'(MAX_LOCK - 1);

    state_e            state_q, state_d;
    mst_t              rr_q, rr_d;
    logic [LOCK_W-1:0] cnt_q, cnt_d;

    always_comb begin
        grant   = 2'b00;
        owner   = rr_q;
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB: begin
                if (req != 2'b00) begin
                    owner        = (req == 2'b11) ? rr_q : req[1];
                    grant[owner] = 1'b1;
                    rr_d         = ~owner;
                    if (lock[owner] && MAX_LOCK > 1) begin
                        state_d = owner ? OWN1 : OWN0;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            OWN0, OWN1: begin
                owner        = (state_q == OWN1);
                grant[owner] = req[owner];
                rr_d         = ~owner;
                if (req[owner] && lock[owner])
                    cnt_d = cnt_q - 1'b1;
                // the exit-cycle access is still granted above
                if (!req[owner] || !lock[owner] || cnt_d == '0)
                    state_d = ARB;
            end
            default: state_d = ARB;
        endcase
        if (reset)
            grant = 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_arb_2m.sv
// Two-master arbiter/sequencer for a single-port byte-enabled RAM.
// Define RAM_ARB_STATS_EN to add grant/conflict counters and stats_clr.
module ram_arb_2m import ram_arb_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                reset,
    ram_arb_if.slave            m0,
    ram_arb_if.slave            m1,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [31:0]         gnt_cnt0,
    output logic [31:0]         gnt_cnt1,
    output logic [31:0]         conflict_cnt
`endif
);

    logic [1:0] req, lock, grant;
    mst_t       owner;

    assign req  = {m1.read | m1.write, m0.read | m0.write};
    assign lock = {m1.lock, m0.lock};

    ram_arb_rr #(.MAX_LOCK(MAX_LOCK)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .grant (grant),
        .owner (owner)
    );

    logic              any_gnt, gnt_wr, gnt_rd;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_pend_q, rd_pend_d;
    mst_t              rd_owner_q, rd_owner_d;

    always_comb begin
        any_gnt        = |grant;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        ram_byteenable = '0;
        gnt_wr         = 1'b0;
        if (grant[0]) begin
            addr_d         = m0.address;
            wdata_d        = m0.writedata;
            ram_byteenable = m0.byteenable;
            gnt_wr         = m0.write;
        end else if (grant[1]) begin
            addr_d         = m1.address;
            wdata_d        = m1.writedata;
            ram_byteenable = m1.byteenable;
            gnt_wr         = m1.write;
        end
        gnt_rd     = any_gnt & ~gnt_wr;
        rd_pend_d  = gnt_rd;
        rd_owner_d = gnt_rd ? owner : rd_owner_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ram_address    = addr_d;
    assign ram_writedata  = wdata_d;
    assign ram_chipselect = any_gnt;
    assign ram_write      = gnt_wr;
    // clken stays up through the return cycle so q cannot move under it
    assign ram_clken      = any_gnt | rd_pend_q;

    assign m0.waitrequest   = reset | (req[0] & ~grant[0]);
    assign m1.waitrequest   = reset | (req[1] & ~grant[1]);
    assign m0.readdatavalid = rd_pend_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_pend_q & rd_owner_q;
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;

`ifdef RAM_ARB_STATS_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [31:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        gnt_cnt0_d     = gnt_cnt0_q + {31'd0, grant[0]};
        gnt_cnt1_d     = gnt_cnt1_q + {31'd0, grant[1]};
        conflict_cnt_d = conflict_cnt_q + {31'd0, &req};
        if (stats_clr) begin
            gnt_cnt0_d     = '0;
            gnt_cnt1_d     = '0;
            conflict_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
